// File: rtl/snake_kbd_pkg.sv
// Shared constants for the keyboard move queue: direction codes, scancodes, parser states.
// Latency: n/a (package only).
// Backpressure: n/a.
package snake_kbd_pkg;

  // Direction codes driven on move
  localparam logic [2:0] MV_NONE  = 3'd0;
  localparam logic [2:0] MV_UP    = 3'd1;
  localparam logic [2:0] MV_DOWN  = 3'd2;
  localparam logic [2:0] MV_LEFT  = 3'd3;
  localparam logic [2:0] MV_RIGHT = 3'd4;

  // PS/2 set-2 scancodes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } parse_state_t;

  // 180-degree counterpart of a direction; NONE maps to NONE
  function automatic logic [2:0] opposite(input logic [2:0] dir);
    case (dir)
      MV_UP:    opposite = MV_DOWN;
      MV_DOWN:  opposite = MV_UP;
      MV_LEFT:  opposite = MV_RIGHT;
      MV_RIGHT: opposite = MV_LEFT;
      default:  opposite = MV_NONE;
    endcase
  endfunction

endpackage

// File: rtl/kbd_move_queue_if.sv
// Byte-in / direction-out bundle between the PS/2 receiver, game tick and snake logic.
// Latency: n/a (wires only).
// Backpressure: none; byte_valid and step are strobes, the queue absorbs bursts.
interface kbd_move_queue_if #(parameter int QUEUE_DEPTH = 2);
  logic [7:0]                   byte_data;
  logic                         byte_valid;
  logic                         step;
  logic [2:0]                   move;
  logic                         pause;
  logic [$clog2(QUEUE_DEPTH):0] q_count;
  logic                         drop;

  modport master (output byte_data, byte_valid, step,
                  input  move, pause, q_count, drop);
  modport slave  (input  byte_data, byte_valid, step,
                  output move, pause, q_count, drop);
endinterface

// File: rtl/move_fifo.sv
// Small synchronous FIFO of direction codes with head and tail peek.
// Latency: push visible in count/tail the cycle after i_push; head is combinational.
// Backpressure: push while full is discarded unless a pop happens in the same cycle.
module move_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [W-1:0]            i_push_dat,
  input  logic                    i_pop,
  output logic [W-1:0]            o_head,
  output logic [W-1:0]            o_tail,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [AW:0]  w_tail_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign o_count    = r_wr_ptr - r_rd_ptr;
  assign o_full     = (o_count == CNT_FULL);
  assign o_empty    = (o_count == '0);
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  assign w_tail_ptr = r_wr_ptr - PTR_ONE;
  assign o_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign o_tail     = r_mem[w_tail_ptr[AW-1:0]];

  // pointer update; a same-cycle pop frees the slot the push lands in
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // storage needs no reset; entries are only read once counted
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/kbd_move_queue.sv
// Scancode bytes -> snake direction commands with repeat/reversal filtering and a turn FIFO.
// Latency: move/pause/drop/q_count update one cycle after the byte_valid or step strobe.
// Backpressure: none upstream; a turn arriving with the FIFO full (and no pop) is dropped.
// Optional WASD_EN: when defined, W/S/A/D make codes steer like the arrow keys.
module kbd_move_queue
  import snake_kbd_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 2,
  parameter int PREFIX_TIMEOUT = 2_500_000
) (
  input  logic              clk,
  input  logic              rst,
  kbd_move_queue_if.slave   bus
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  parse_state_t  r_state, w_state_nxt;
  logic [TW-1:0] r_tmo_cnt, w_tmo_nxt;
  logic          w_make, w_brk, w_ext;
  logic [8:0]    w_key;
  logic [2:0]    w_key_dir;
  logic          w_key_pause, w_known, w_repeat, w_act, w_accept;
  logic [8:0]    r_held_key;
  logic          r_held_vld;
  logic [2:0]    r_move;
  logic          r_pause, r_drop;
  logic [2:0]    w_head, w_tail, w_ref;
  logic [CW-1:0] w_count;
  logic          w_full, w_empty, w_pop;

  // parser state and prefix timeout counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmo_cnt <= w_tmo_nxt;
    end
  end

  // parser next state: prefixes advance the FSM, everything else yields a make or break event
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo_cnt;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    if (bus.byte_valid) begin
      w_tmo_nxt = '0;
      case (r_state)
        ST_IDLE: begin
          if (bus.byte_data == SC_EXT)      w_state_nxt = ST_EXT;
          else if (bus.byte_data == SC_BRK) w_state_nxt = ST_BRK;
          else                              w_make = 1'b1;
        end
        ST_EXT: begin
          if (bus.byte_data == SC_BRK) begin
            w_state_nxt = ST_EXT_BRK;
          end else begin
            w_make      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_brk       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else if (r_state != ST_IDLE) begin
      // a stalled prefix gives up so a lost byte cannot poison the next key
      if (r_tmo_cnt == TMO_LAST) begin
        w_state_nxt = ST_IDLE;
        w_tmo_nxt   = '0;
      end else begin
        w_tmo_nxt = r_tmo_cnt + TMO_ONE;
      end
    end else begin
      w_tmo_nxt = '0;
    end
  end

  assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
  assign w_key = {w_ext, bus.byte_data};

  // key map: extended arrows steer, plain space pauses
  always_comb begin
    w_key_dir   = MV_NONE;
    w_key_pause = 1'b0;
    if (w_ext) begin
      case (bus.byte_data)
        SC_UP:    w_key_dir = MV_UP;
        SC_DOWN:  w_key_dir = MV_DOWN;
        SC_LEFT:  w_key_dir = MV_LEFT;
        SC_RIGHT: w_key_dir = MV_RIGHT;
        default:  w_key_dir = MV_NONE;
      endcase
    end else begin
      case (bus.byte_data)
        SC_SPACE: w_key_pause = 1'b1;
`ifdef WASD_EN
        SC_W:     w_key_dir = MV_UP;
        SC_S:     w_key_dir = MV_DOWN;
        SC_A:     w_key_dir = MV_LEFT;
        SC_D:     w_key_dir = MV_RIGHT;
`endif
        default:  w_key_pause = 1'b0;
      endcase
    end
  end

  assign w_known  = w_key_pause || (w_key_dir != MV_NONE);
  assign w_repeat = r_held_vld && (r_held_key == w_key);
  assign w_act    = w_make && w_known && !w_repeat;

  // reversal guard compares against the newest pending turn, or the live heading if none queued
  assign w_ref    = (w_count != '0) ? w_tail : r_move;
  assign w_accept = w_act && (w_key_dir != MV_NONE) &&
                    ((w_ref == MV_NONE) ||
                     ((w_key_dir != w_ref) && (w_key_dir != opposite(w_ref))));
  assign w_pop    = bus.step && !w_empty;

  move_fifo #(.DEPTH(QUEUE_DEPTH), .W(3)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_accept),
    .i_push_dat (w_key_dir),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_tail     (w_tail),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // registered outputs and held-key tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_move     <= MV_NONE;
      r_pause    <= 1'b0;
      r_drop     <= 1'b0;
      r_held_vld <= 1'b0;
      r_held_key <= '0;
    end else begin
      r_drop <= w_accept && w_full && !w_pop;
      if (w_pop) r_move <= w_head;
      if (w_act && w_key_pause) r_pause <= ~r_pause;
      if (w_act) begin
        r_held_vld <= 1'b1;
        r_held_key <= w_key;
      end else if (w_brk && r_held_vld && (r_held_key == w_key)) begin
        r_held_vld <= 1'b0;
      end
    end
  end

  assign bus.move    = r_move;
  assign bus.pause   = r_pause;
  assign bus.drop    = r_drop;
  assign bus.q_count = w_count;

endmodule

// File: tb/tb_kbd_move_queue.sv
// Scoreboard bench for kbd_move_queue: directed test-plan sequences plus random byte streams.
// A queue-based reference model predicts move/pause/drop events and queue depth.
module tb_kbd_move_queue;
  localparam int DEPTH = 2;
  localparam int TMO   = 20;

  localparam logic [1:0] K_MOVE  = 2'd0;
  localparam logic [1:0] K_PAUSE = 2'd1;
  localparam logic [1:0] K_DROP  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] val;
  } evt_t;

  logic clk;
  logic rst;
  kbd_move_queue_if #(.QUEUE_DEPTH(DEPTH)) bus();

  kbd_move_queue #(.QUEUE_DEPTH(DEPTH), .PREFIX_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  evt_t       exp_q[$];
  logic [2:0] m_q[$];
  logic [2:0] m_move;
  bit         m_pause;
  bit         m_hvld;
  logic [8:0] m_hkey;
  bit         m_pext, m_pbrk;
  int         m_idle;

  // monitor control (written only by the stimulus process)
  bit         run = 0;
  bit         want_rst = 0;
  bit         want_vld = 0;
  bit         fin = 0;
  string      want_name;
  logic [2:0] want_move;
  int         want_q;

  logic [2:0] prev_move;
  bit         prev_pause;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp_v);
    end
  endtask

  task automatic expect_evt(input logic [1:0] kind, input logic [2:0] val);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual=kind%0d/val%0d required=none", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL event actual=kind%0d/val%0d required=kind%0d/val%0d", kind, val, e.kind, e.val);
      end
    end
  endtask

  // monitor: observes outputs mid-cycle and reconciles them with the scoreboard
  always @(negedge clk) begin
    if (run) begin
      if (want_rst) begin
        chk("rst_move", int'(bus.move), 0);
        chk("rst_pause", int'(bus.pause), 0);
        chk("rst_q_count", int'(bus.q_count), 0);
        chk("rst_drop", int'(bus.drop), 0);
        prev_move  = 3'd0;
        prev_pause = 1'b0;
      end else begin
        if (bus.move !== prev_move) begin
          expect_evt(K_MOVE, bus.move);
          prev_move = bus.move;
        end
        if (bus.pause !== prev_pause) begin
          expect_evt(K_PAUSE, {2'b00, bus.pause});
          prev_pause = bus.pause;
        end
        if (bus.drop !== 1'b0) expect_evt(K_DROP, 3'd0);
        chk("q_count", int'(bus.q_count), m_q.size());
      end
      if (want_vld) begin
        chk({want_name, "_move"}, int'(bus.move), int'(want_move));
        chk({want_name, "_q"}, int'(bus.q_count), want_q);
      end
      if (fin) chk("pending_events", exp_q.size(), 0);
    end
  end

  // map {ext,code} to 1..4 direction, 5 pause, 0 unmapped
  function automatic int key_of(input logic [8:0] key);
    case (key)
      9'h175: key_of = 1;
      9'h172: key_of = 2;
      9'h16B: key_of = 3;
      9'h174: key_of = 4;
      9'h029: key_of = 5;
`ifdef WASD_EN
      9'h01D: key_of = 1;
      9'h01B: key_of = 2;
      9'h01C: key_of = 3;
      9'h023: key_of = 4;
`endif
      default: key_of = 0;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_move = 3'd0; m_pause = 0; m_hvld = 0; m_hkey = '0;
    m_pext = 0; m_pbrk = 0; m_idle = 0;
  endtask

  // one clock edge of the reference behaviour, from the inputs applied before that edge
  task automatic model_edge(input bit bv, input logic [7:0] bd, input bit st);
    bit pop, mk, bk, ex, push, pz_e, drop_e;
    logic [8:0] key;
    int k, rf;
    pop = st && (m_q.size() > 0);
    mk = 0; bk = 0; ex = 0;
    if (bv) begin
      m_idle = 0;
      if (!m_pext && !m_pbrk) begin
        if (bd == 8'hE0) m_pext = 1;
        else if (bd == 8'hF0) m_pbrk = 1;
        else mk = 1;
      end else if (!m_pbrk) begin
        if (bd == 8'hF0) m_pbrk = 1;
        else begin mk = 1; ex = 1; m_pext = 0; end
      end else begin
        bk = 1; ex = m_pext; m_pext = 0; m_pbrk = 0;
      end
    end else if (m_pext || m_pbrk) begin
      m_idle++;
      if (m_idle >= TMO) begin m_pext = 0; m_pbrk = 0; m_idle = 0; end
    end
    key = {ex, bd};
    k = key_of(key);
    push = 0; pz_e = 0; drop_e = 0;
    if (mk && k != 0 && !(m_hvld && m_hkey == key)) begin
      m_hvld = 1; m_hkey = key;
      if (k == 5) pz_e = 1;
      else begin
        rf = (m_q.size() > 0) ? int'(m_q[$]) : int'(m_move);
        // directions pair up as (1,2) and (3,4): same pair means equal or reversed
        if (rf == 0 || ((k - 1) / 2) != ((rf - 1) / 2)) begin
          if (m_q.size() < DEPTH || pop) push = 1;
          else drop_e = 1;
        end
      end
    end
    if (bk && m_hvld && m_hkey == key) m_hvld = 0;
    if (pop) begin
      m_move = m_q.pop_front();
      exp_q.push_back({K_MOVE, m_move});
    end
    if (push) m_q.push_back(3'(k));
    if (pz_e) begin
      m_pause = !m_pause;
      exp_q.push_back({K_PAUSE, {2'b00, m_pause}});
    end
    if (drop_e) exp_q.push_back({K_DROP, 3'd0});
  endtask

  task automatic tick(input bit bv, input logic [7:0] bd, input bit st);
    @(negedge clk);
    bus.byte_valid = bv;
    bus.byte_data  = bd;
    bus.step       = st;
    @(posedge clk);
    want_vld = 0;
    want_rst = 0;
    #1;
    model_edge(bv, bd, st);
    bus.byte_valid = 0;
    bus.byte_data  = 8'h00;
    bus.step       = 0;
  endtask

  task automatic send(input logic [7:0] b);  tick(1, b, 0); endtask
  task automatic ext(input logic [7:0] b);   send(8'hE0); send(b); endtask
  task automatic step_once();                tick(0, 8'h00, 1); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 8'h00, 0);
  endtask

  task automatic want(input string nm, input logic [2:0] mv, input int q);
    want_name = nm; want_move = mv; want_q = q; want_vld = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    bus.byte_valid = 0; bus.step = 0; bus.byte_data = 8'h00;
    @(posedge clk);
    want_vld = 0;
    #1;
    rst = 1;
    model_reset();
    want_rst = 1;
    run = 1;
  endtask

  logic [7:0] pool [14];

  initial begin
    rst = 0;
    bus.byte_valid = 0; bus.byte_data = 8'h00; bus.step = 0;
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29,
             8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h12, 8'hE0, 8'hE0};
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // first turn, then typematic repeats
    ext(8'h75); step_once(); want("first_up", 3'd1, 0);
    for (int i = 0; i < 5; i++) ext(8'h75);
    want("typematic", 3'd1, 0);

    // reversal against move, then against queued tail
    ext(8'h72); want("rev_move", 3'd1, 0);
    ext(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B);
    ext(8'h74); want("rev_tail", 3'd1, 1);
    step_once(); want("pop_left", 3'd3, 0);
    ext(8'h75); step_once(); want("back_up", 3'd1, 0);

    // overflow of the two-entry queue
    ext(8'h6B); ext(8'h72); ext(8'h74); want("overflow", 3'd1, 2);
    step_once(); want("pop1", 3'd3, 1);
    step_once(); want("pop2", 3'd2, 0);
    step_once(); want("pop_empty", 3'd2, 0);

    // pause toggle with release in between
    send(8'h29); send(8'hF0); send(8'h29); send(8'h29);
    want("pause_q", 3'd2, 0);

    // prefix timeout, and a prefix completed just before it expires
    send(8'hE0); idle(TMO + 2); send(8'h75); want("tmo", 3'd2, 0);
    send(8'hE0); idle(TMO - 3); send(8'h74); want("pre_tmo", 3'd2, 1);
    step_once(); want("pop_right", 3'd4, 0);
    send(8'h1D);
`ifdef WASD_EN
    want("wasd", 3'd4, 1);
`else
    want("wasd", 3'd4, 0);
`endif

    // full queue with push and step in the same cycle
    do_reset();
    ext(8'h75); ext(8'h6B); send(8'hE0); tick(1, 8'h72, 1);
    want("full_push_pop", 3'd1, 2);

    // reset in the middle of an extended prefix
    send(8'hE0);
    do_reset();
    send(8'h75); want("post_rst", 3'd0, 0);

    // random byte streams against the model
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 3) != 0, pool[$urandom_range(0, 13)], $urandom_range(0, 5) == 0);
    end
    for (int i = 0; i < DEPTH + 1; i++) step_once();

    idle(2);
    fin = 1;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kbd_move_queue.md
Name: kbd_move_queue

Overview:
- Sits between the PS/2 byte receiver and the snake movement/render logic.
- Turns raw scancode bytes into direction commands. It parses the E0 (extended) and F0 (break) prefixes and suppresses typematic repeats.
- It rejects 180° reversals and buffers quick successive turns in a small FIFO.
- The FIFO is drained one entry per game step, so fast double-turns are never lost between snake moves.

Parameters:
- QUEUE_DEPTH, 2: direction FIFO depth (power of two, 2..8).
- PREFIX_TIMEOUT, 2_500_000: clk cycles allowed after an E0/F0 prefix before the parser aborts to IDLE.

Ports:
- clk  in  1  system clock; the whole block is single-clock.
- rst  in  1  synchronous, active-low reset.
- byte_data  in  8  scancode byte from the PS/2 receiver.
- byte_valid  in  1  one-cycle strobe; byte_data is valid in that cycle.
- step  in  1  one-cycle game-tick strobe; pops one queued direction.
- move  out  3  current direction: 0 NONE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT.
- pause  out  1  pause level, toggled by the space key.
- q_count  out  $clog2(QUEUE_DEPTH)+1  entries currently queued.
- drop  out  1  one-cycle pulse when an accepted direction is discarded because the FIFO is full.

Behaviour:
- Reset (rst=0 at a clk edge):
  - move=NONE, pause=0, q_count=0, drop=0.
  - Parser goes to IDLE, held key cleared, timeout counter cleared.
  - Reset mid-prefix discards the prefix.
- Parser FSM states: IDLE, EXT, BRK, EXT_BRK. All transitions occur only on byte_valid, except timeout.
  - IDLE: E0→EXT; F0→BRK; any other byte is a normal make code → classify, stay IDLE.
  - EXT: F0→EXT_BRK; any other byte is an extended make → classify, →IDLE.
  - BRK: byte is a normal break; if it equals held key, clear held key; →IDLE.
  - EXT_BRK: same as BRK for extended codes; →IDLE.
  - Timeout: in EXT/BRK/EXT_BRK, PREFIX_TIMEOUT cycles with no byte_valid → IDLE. The counter resets on every byte_valid.
- Key map:
  - Extended codes: 75 UP, 72 DOWN, 6B LEFT, 74 RIGHT.
  - Normal code 29 is PAUSE.
  - All other codes are ignored and leave held key unchanged.
- Held key: a recognised make whose {ext,code} equals the held key is a typematic repeat and is ignored. Otherwise it becomes the held key and is acted on.
- PAUSE make: toggles pause the cycle after the byte; never queued.
- Direction make, reference direction:
  - REF = FIFO tail if q_count>0, else move.
  - Direction is accepted iff REF==NONE, or it is neither equal nor opposite to REF.
  - Opposite pairs: UP/DOWN, LEFT/RIGHT.
- Push:
  - An accepted direction is pushed the cycle after byte_valid.
  - If the FIFO is full and no pop occurs in the same cycle, the entry is discarded and drop pulses for 1 cycle.
- Pop:
  - On step with q_count>0, move ← head the next cycle.
  - step with an empty FIFO leaves move unchanged.
  - No bypass: a direction pushed in the same cycle as step is never popped by that step.
- Simultaneous push+pop: both occur and q_count is unchanged. When full, the pop frees the slot, so there is no drop.
- REF is evaluated from pre-cycle state.
- move, pause and drop are registered outputs; q_count reflects registered pointers.

Optional Feature:
- Macro WASD_EN.
- Defined: normal make codes 1D→UP, 1B→DOWN, 1C→LEFT, 23→RIGHT, with the same reversal, repeat and break handling as the arrows.
- Undefined: these codes are ignored like any unmapped key.

Decomposition:
- Package snake_kbd_pkg holds:
  - move code localparams (NONE..RIGHT);
  - scancode constants (E0, F0, arrows, space, WASD);
  - parser state enum;
  - function opposite(dir).
- One sub-module, move_fifo: parameterised synchronous FIFO with push/pop/count/full, peek of head and tail. The parser, reversal guard and pause live in kbd_move_queue.

Test Plan:
- Reset, then E0 75, then step → move=UP, q_count returns 0; repeat E0 75 ×5 (typematic) without break → q_count stays 0.
- move=UP; send E0 72 → rejected as reversal, q_count=0; send E0 6B, E0 F0 6B, E0 74 → queue not changed by E0 74, since it is opposite the tail LEFT.
- move=UP, QUEUE_DEPTH=2; queue LEFT, then DOWN, then a third distinct press → drop pulses once, q_count=2; two steps → move LEFT then DOWN.
- Byte 29 → pause=1; F0 29, then 29 → pause=0; q_count unaffected.
- E0 then no byte for PREFIX_TIMEOUT cycles, then 75 → treated as a normal unmapped code, move unchanged; with WASD_EN, 1D → UP queued.
- FIFO full, push and step in the same cycle → no drop, q_count stays 2; rst=0 held one edge mid-EXT → all outputs at reset values, next byte 75 is ignored.
